// File: rtl/pipe_stage_reg.sv
// Purpose : generic pipeline stage register (instr + payload + ctrl) with valid/ready and a 2-entry skid.
// Latency : 1 cycle from input transfer to out_valid when empty; sustained 1 entry/cycle with out_ready=1.
// Backpressure: in_ready is registered (= !skid valid); a stalled stage absorbs one extra entry in the skid.
//
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready, in_instr, in_data, in_ctrl, bubble_in  - upstream side
//   flush                                                      - synchronous squash of held entries
//   out_valid/out_ready, out_instr, out_data, out_ctrl          - downstream side
//   bubble_cnt, stall_cnt                                       - perf counters, present only when
//                                                                 PIPE_STAGE_PERF_EN is defined
module pipe_stage_reg #(
  parameter int                 INSTR_W   = 16,
  parameter int                 DATA_W    = 64,
  parameter int                 CTRL_W    = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int                 CNT_W     = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic               bubble_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [DATA_W-1:0]  out_data,
  output logic [CTRL_W-1:0]  out_ctrl
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);

  logic               mainValid, skidValid;
  logic [INSTR_W-1:0] mainInstr, skidInstr;
  logic [DATA_W-1:0]  mainData, skidData;
  logic [CTRL_W-1:0]  mainCtrl, skidCtrl;

  logic               inFire, outFire;
  logic [INSTR_W-1:0] capInstr;
  logic [CTRL_W-1:0]  capCtrl;

  assign in_ready  = ~skidValid;
  assign inFire    = in_valid & in_ready;
  assign outFire   = mainValid & out_ready;

  // A bubble keeps the payload but neutralises the instruction and all side effects.
  assign capInstr  = bubble_in ? NOP_INSTR : in_instr;
  assign capCtrl   = bubble_in ? '0 : in_ctrl;

  assign out_valid = mainValid;
  assign out_instr = mainValid ? mainInstr : NOP_INSTR;
  assign out_ctrl  = mainValid ? mainCtrl : '0;
  assign out_data  = mainData;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      mainInstr <= NOP_INSTR;
      skidInstr <= NOP_INSTR;
      mainData  <= '0;
      skidData  <= '0;
      mainCtrl  <= '0;
      skidCtrl  <= '0;
    end else if (flush) begin
      // Squash wins over everything, including a same-cycle input transfer.
      mainValid <= 1'b0;
      skidValid <= 1'b0;
    end else if (!mainValid) begin
      // Skid is necessarily empty here, so the input goes straight to main.
      if (inFire) begin
        mainValid <= 1'b1;
        mainInstr <= capInstr;
        mainData  <= in_data;
        mainCtrl  <= capCtrl;
      end
    end else if (outFire) begin
      if (skidValid) begin
        // in_ready is low whenever skid holds an entry, so no input can arrive now.
        mainInstr <= skidInstr;
        mainData  <= skidData;
        mainCtrl  <= skidCtrl;
        skidValid <= 1'b0;
      end else if (inFire) begin
        mainInstr <= capInstr;
        mainData  <= in_data;
        mainCtrl  <= capCtrl;
      end else begin
        mainValid <= 1'b0;
      end
    end else if (inFire) begin
      // Main is stalled: park the new entry behind it.
      skidValid <= 1'b1;
      skidInstr <= capInstr;
      skidData  <= in_data;
      skidCtrl  <= capCtrl;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] bubbleCnt, stallCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubbleCnt <= '0;
      stallCnt  <= '0;
    end else begin
      // Both counters stick at all-ones rather than wrapping.
      if (inFire && bubble_in && !flush && (bubbleCnt != {CNT_W{1'b1}}))
        bubbleCnt <= bubbleCnt + 1'b1;
      if (mainValid && !out_ready && (stallCnt != {CNT_W{1'b1}}))
        stallCnt <= stallCnt + 1'b1;
    end
  end

  assign bubble_cnt = bubbleCnt;
  assign stall_cnt  = stallCnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [15:0] inInstr;
  logic [63:0] inData;
  logic [3:0]  inCtrl;
  logic        bubbleIn;
  logic        flush;
  logic        outValid;
  logic        outReady;
  logic [15:0] outInstr;
  logic [63:0] outData;
  logic [3:0]  outCtrl;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] bubbleCnt;
  logic [15:0] stallCnt;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk       (clk),
    .rst       (rstN),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_instr  (inInstr),
    .in_data   (inData),
    .in_ctrl   (inCtrl),
    .bubble_in (bubbleIn),
    .flush     (flush),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_instr (outInstr),
    .out_data  (outData),
    .out_ctrl  (outCtrl)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .bubble_cnt(bubbleCnt),
    .stall_cnt (stallCnt)
`endif
  );

  typedef struct {
    logic        inValid;
    logic [15:0] instr;
    logic [3:0]  ctrl;
    logic [63:0] data;
    logic        bubble;
    logic        flush;
    logic        outReady;
    logic        expValid;
    logic        expReady;
    logic [15:0] expInstr;
    logic [3:0]  expCtrl;
    logic [63:0] expData;
  } vec_t;

  typedef struct {
    logic [15:0] instr;
    logic [63:0] data;
    logic [3:0]  ctrl;
  } ent_t;

  vec_t tbl[$];
  ent_t model[$];

  function automatic vec_t mk(logic iv, logic [15:0] ins, logic [3:0] c, logic [63:0] d,
                              logic b, logic f, logic ordy,
                              logic ev, logic er, logic [15:0] ei, logic [3:0] ec, logic [63:0] ed);
    vec_t r;
    r.inValid = iv; r.instr = ins; r.ctrl = c; r.data = d; r.bubble = b; r.flush = f;
    r.outReady = ordy; r.expValid = ev; r.expReady = er; r.expInstr = ei; r.expCtrl = ec;
    r.expData = ed;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idleInputs();
    inValid = 1'b0; inInstr = '0; inData = '0; inCtrl = '0;
    bubbleIn = 1'b0; flush = 1'b0; outReady = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, " out_valid"}, 64'(outValid), 64'd0);
    chk({tag, " in_ready"},  64'(inReady),  64'd1);
    chk({tag, " out_instr"}, 64'(outInstr), 64'(NOP));
    chk({tag, " out_ctrl"},  64'(outCtrl),  64'd0);
    chk({tag, " out_data"},  outData,       64'd0);
`ifdef PIPE_STAGE_PERF_EN
    chk({tag, " bubble_cnt"}, 64'(bubbleCnt), 64'd0);
    chk({tag, " stall_cnt"},  64'(stallCnt),  64'd0);
`endif
  endtask

  // Reset pulse placed away from the clock edge; returns just after a falling edge.
  task automatic doReset();
    idleInputs();
    @(negedge clk);
    #2 rstN = 1'b0;
    #1 checkResetOutputs("reset");
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    idleInputs();
    rstN = 1'b0;
    #1 checkResetOutputs("por");
    @(negedge clk);
    rstN = 1'b1;

    // ---------------- table-driven directed vectors ----------------
    // Expected values are the outputs seen after the clock edge that consumes the row.
    // streaming with out_ready=1
    tbl.push_back(mk(1, 16'h1111, 4'h1, 64'h1111, 0, 0, 1,  1, 1, 16'h1111, 4'h1, 64'h1111));
    tbl.push_back(mk(1, 16'h2222, 4'h2, 64'h2222, 0, 0, 1,  1, 1, 16'h2222, 4'h2, 64'h2222));
    tbl.push_back(mk(1, 16'h3333, 4'h3, 64'h3333, 0, 0, 1,  1, 1, 16'h3333, 4'h3, 64'h3333));
    tbl.push_back(mk(0, 16'h0000, 4'h0, 64'h0,    0, 0, 1,  0, 1, NOP,      4'h0, 64'h0));
    // back-pressure: two accepted, third refused until drain
    tbl.push_back(mk(1, 16'h1111, 4'h1, 64'h1111, 0, 0, 0,  1, 1, 16'h1111, 4'h1, 64'h1111));
    tbl.push_back(mk(1, 16'h2222, 4'h2, 64'h2222, 0, 0, 0,  1, 0, 16'h1111, 4'h1, 64'h1111));
    tbl.push_back(mk(1, 16'h3333, 4'h3, 64'h3333, 1, 0, 0,  1, 0, 16'h1111, 4'h1, 64'h1111));
    tbl.push_back(mk(1, 16'h3333, 4'h3, 64'h3333, 0, 0, 1,  1, 1, 16'h2222, 4'h2, 64'h2222));
    tbl.push_back(mk(1, 16'h3333, 4'h3, 64'h3333, 0, 0, 1,  1, 1, 16'h3333, 4'h3, 64'h3333));
    tbl.push_back(mk(0, 16'h0000, 4'h0, 64'h0,    0, 0, 1,  0, 1, NOP,      4'h0, 64'h0));
    // bubble capture
    tbl.push_back(mk(1, 16'h4A5B, 4'hF, 64'h1234, 1, 0, 0,  1, 1, NOP,      4'h0, 64'h1234));
    tbl.push_back(mk(0, 16'h0000, 4'h0, 64'h0,    0, 0, 1,  0, 1, NOP,      4'h0, 64'h0));
    // flush with both entries full and an entry offered
    tbl.push_back(mk(1, 16'hAAAA, 4'h5, 64'hAAAA, 0, 0, 0,  1, 1, 16'hAAAA, 4'h5, 64'hAAAA));
    tbl.push_back(mk(1, 16'hBBBB, 4'h6, 64'hBBBB, 0, 0, 0,  1, 0, 16'hAAAA, 4'h5, 64'hAAAA));
    tbl.push_back(mk(1, 16'hCCCC, 4'h7, 64'hCCCC, 0, 1, 0,  0, 1, NOP,      4'h0, 64'h0));
    // flush while empty discards the offered entry
    tbl.push_back(mk(1, 16'hDDDD, 4'h8, 64'hDDDD, 0, 1, 1,  0, 1, NOP,      4'h0, 64'h0));
    // flush with one entry and a simultaneous transfer
    tbl.push_back(mk(1, 16'hEEEE, 4'h9, 64'hEEEE, 0, 0, 1,  1, 1, 16'hEEEE, 4'h9, 64'hEEEE));
    tbl.push_back(mk(1, 16'hFFFF, 4'hA, 64'hFFFF, 0, 1, 1,  0, 1, NOP,      4'h0, 64'h0));
    tbl.push_back(mk(1, 16'h1234, 4'hB, 64'h1234, 0, 0, 1,  1, 1, 16'h1234, 4'hB, 64'h1234));
    tbl.push_back(mk(0, 16'h0000, 4'h0, 64'h0,    0, 0, 1,  0, 1, NOP,      4'h0, 64'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      inValid = tbl[i].inValid; inInstr = tbl[i].instr; inCtrl = tbl[i].ctrl;
      inData = tbl[i].data; bubbleIn = tbl[i].bubble; flush = tbl[i].flush;
      outReady = tbl[i].outReady;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("row%0d out_valid", i), 64'(outValid), 64'(tbl[i].expValid));
      chk($sformatf("row%0d in_ready", i),  64'(inReady),  64'(tbl[i].expReady));
      chk($sformatf("row%0d out_instr", i), 64'(outInstr), 64'(tbl[i].expInstr));
      chk($sformatf("row%0d out_ctrl", i),  64'(outCtrl),  64'(tbl[i].expCtrl));
      if (tbl[i].expValid)
        chk($sformatf("row%0d out_data", i), outData, tbl[i].expData);
    end
    idleInputs();

    // ---------------- reset in the middle of a full stage ----------------
    inValid = 1'b1; inInstr = 16'h5555; inData = 64'h5555; inCtrl = 4'h3;
    @(posedge clk); @(negedge clk);
    inInstr = 16'h6666; inData = 64'h6666;
    @(posedge clk); @(negedge clk);
    chk("midreset pre in_ready", 64'(inReady), 64'd0);
    inValid = 1'b0;
    #2 rstN = 1'b0;
    #1 checkResetOutputs("midreset");
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkResetOutputs("midreset post");

`ifdef PIPE_STAGE_PERF_EN
    // ---------------- perf counters: 3 bubbles, 5 stalled cycles ----------------
    doReset();
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1; bubbleIn = 1'b1; inInstr = 16'h7000 + 16'(i); inData = 64'(i);
      @(posedge clk); @(negedge clk);
    end
    inValid = 1'b0; bubbleIn = 1'b0; outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
    end
    chk("perf bubble_cnt", 64'(bubbleCnt), 64'd3);
    chk("perf stall_cnt",  64'(stallCnt),  64'd5);
    idleInputs();
`endif

    // ---------------- randomized run against a queue model ----------------
    begin
      int   bubbleModel;
      int   stallModel;
      logic inFireM, outFireM;
      ent_t e;
      doReset();
      model.delete();
      bubbleModel = 0;
      stallModel  = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        inValid  = ($urandom_range(0, 3) != 0);
        outReady = ($urandom_range(0, 2) != 0);
        bubbleIn = ($urandom_range(0, 3) == 0);
        flush    = ($urandom_range(0, 15) == 0);
        inInstr  = 16'($urandom);
        inCtrl   = 4'($urandom);
        inData   = {32'($urandom), 32'($urandom)};

        // Outputs reflect the state left by the previous edge.
        chk("rnd out_valid", 64'(outValid), 64'(model.size() != 0));
        chk("rnd in_ready",  64'(inReady),  64'(model.size() < 2));
        if (model.size() != 0) begin
          chk("rnd out_instr", 64'(outInstr), 64'(model[0].instr));
          chk("rnd out_ctrl",  64'(outCtrl),  64'(model[0].ctrl));
          chk("rnd out_data",  outData,       model[0].data);
        end else begin
          chk("rnd idle out_instr", 64'(outInstr), 64'(NOP));
          chk("rnd idle out_ctrl",  64'(outCtrl),  64'd0);
        end
`ifdef PIPE_STAGE_PERF_EN
        chk("rnd bubble_cnt", 64'(bubbleCnt), 64'(bubbleModel));
        chk("rnd stall_cnt",  64'(stallCnt),  64'(stallModel));
`endif

        inFireM  = inValid && (model.size() < 2);
        outFireM = (model.size() != 0) && outReady;
        @(posedge clk);
        if (model.size() != 0 && !outReady && stallModel < 65535) stallModel++;
        if (inFireM && bubbleIn && !flush && bubbleModel < 65535) bubbleModel++;
        if (flush) begin
          model.delete();
        end else begin
          if (outFireM) void'(model.pop_front());
          if (inFireM) begin
            e.instr = bubbleIn ? NOP : inInstr;
            e.ctrl  = bubbleIn ? 4'h0 : inCtrl;
            e.data  = inData;
            model.push_back(e);
          end
        end
        @(negedge clk);
      end
    end

    idleInputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
